// File: rtl/bsg_fpu_add_sub_arbiter.sv
// Round-robin front end that shares one in-order pipelined FP add/sub unit among num_req_p requesters.
// A tag FIFO remembers who issued each in-flight op so results and flags go back to the right requester.
module bsg_fpu_add_sub_arbiter
  #(parameter int e_p       = 8
   ,parameter int m_p       = 23
   ,parameter int num_req_p = 4
   ,parameter int els_p     = 4
   )
   (input  logic                                    clk_i
   ,input  logic                                    reset_i

   ,input  logic [num_req_p-1:0]                    v_i
   ,input  logic [num_req_p*(e_p+m_p+1)-1:0]        a_i
   ,input  logic [num_req_p*(e_p+m_p+1)-1:0]        b_i
   ,input  logic [num_req_p-1:0]                    sub_i
   ,output logic [num_req_p-1:0]                    ready_o

   ,output logic [num_req_p-1:0]                    v_o
   ,output logic [e_p+m_p:0]                        z_o
   ,output logic [3:0]                              flags_o
   ,input  logic [num_req_p-1:0]                    yumi_i

   ,output logic                                    fpu_v_o
   ,output logic [e_p+m_p:0]                        fpu_a_o
   ,output logic [e_p+m_p:0]                        fpu_b_o
   ,output logic                                    fpu_sub_o
   ,output logic                                    fpu_en_o
   ,input  logic                                    fpu_ready_i
   ,input  logic                                    fpu_v_i
   ,input  logic [e_p+m_p:0]                        fpu_z_i
   ,input  logic [3:0]                              fpu_flags_i
   ,output logic                                    fpu_yumi_o

   ,output logic                                    error_o
   );

   localparam int w_lp     = e_p + m_p + 1;
   localparam int tag_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [tag_w_lp-1:0] tags_r [els_p];
   logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
   logic [cnt_w_lp-1:0] count_r;
   logic [tag_w_lp-1:0] rr_ptr_r;
   logic                error_r;

   logic [num_req_p-1:0] v_rot;
   logic [tag_w_lp:0]    grant_ofs, grant_sum;
   logic [tag_w_lp-1:0]  grant_idx;
   logic                 grant_v;
   logic                 can_issue;
   logic                 issue;
   logic [tag_w_lp-1:0]  head_tag;
   logic                 not_empty;
   logic                 res_v;
   logic                 deq;
   logic                 err_now;

   // Rotate requests so the search starts at rr_ptr_r; lowest set bit wins.
   always_comb begin
      v_rot     = num_req_p'({v_i, v_i} >> rr_ptr_r);
      grant_ofs = '0;
      for (int i = num_req_p-1; i >= 0; i--) begin
         if (v_rot[i]) grant_ofs = (tag_w_lp+1)'(i);
      end
      grant_sum = grant_ofs + {1'b0, rr_ptr_r};
      if (grant_sum >= (tag_w_lp+1)'(num_req_p))
         grant_idx = tag_w_lp'(grant_sum - (tag_w_lp+1)'(num_req_p));
      else
         grant_idx = grant_sum[tag_w_lp-1:0];
   end

   assign grant_v   = |v_i;
   assign can_issue = fpu_ready_i & (count_r < cnt_w_lp'(els_p)) & ~reset_i;
   assign issue     = can_issue & grant_v;

   assign ready_o   = issue ? ({{(num_req_p-1){1'b0}}, 1'b1} << grant_idx) : '0;
   assign fpu_v_o   = issue;
   assign fpu_a_o   = a_i[grant_idx*w_lp +: w_lp];
   assign fpu_b_o   = b_i[grant_idx*w_lp +: w_lp];
   assign fpu_sub_o = sub_i[grant_idx];
   assign fpu_en_o  = 1'b1;

   assign head_tag   = tags_r[rd_ptr_r];
   assign not_empty  = (count_r != '0);
   assign res_v      = fpu_v_i & not_empty & ~reset_i;
   assign v_o        = res_v ? ({{(num_req_p-1){1'b0}}, 1'b1} << head_tag) : '0;
   assign z_o        = fpu_z_i;
   assign flags_o    = fpu_flags_i;
   assign fpu_yumi_o = res_v & yumi_i[head_tag];
   assign deq        = fpu_yumi_o;

   // A result with nothing outstanding, or a yumi on a lane that has no result.
   assign err_now = (fpu_v_i & ~not_empty) | (|(yumi_i & ~v_o));
   assign error_o = error_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
         rr_ptr_r <= '0;
         error_r  <= 1'b0;
      end else begin
         if (issue) begin
            wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(els_p-1)) ? '0 : wr_ptr_r + 1'b1;
            rr_ptr_r <= (grant_idx == tag_w_lp'(num_req_p-1)) ? '0 : grant_idx + 1'b1;
         end
         if (deq)
            rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p-1)) ? '0 : rd_ptr_r + 1'b1;
         case ({issue, deq})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
         if (err_now)
            error_r <= 1'b1;
      end
   end

   // Tag storage needs no reset: entries are only read while count_r is nonzero.
   always_ff @(posedge clk_i) begin
      if (issue)
         tags_r[wr_ptr_r] <= grant_idx;
   end

endmodule

// File: tb/tb_bsg_fpu_add_sub_arbiter.sv
// Directed bench for bsg_fpu_add_sub_arbiter with a behavioural 3-cycle in-order add/sub unit.
// Grant vectors are hand-computed; results are matched in issue order against a bench-side queue.
module tb_bsg_fpu_add_sub_arbiter;
   localparam int W = 32;
   localparam int N = 4;

   logic           clk_i   = 1'b0;
   logic           reset_i = 1'b1;
   logic [N-1:0]   v_i     = '0;
   logic [N*W-1:0] a_i     = '0;
   logic [N*W-1:0] b_i     = '0;
   logic [N-1:0]   sub_i   = '0;
   logic [N-1:0]   ready_o, v_o, yumi_i;
   logic [W-1:0]   z_o, fpu_a_o, fpu_b_o, fpu_z_i;
   logic [3:0]     flags_o, fpu_flags_i;
   logic           fpu_v_o, fpu_sub_o, fpu_en_o, fpu_ready_i, fpu_v_i, fpu_yumi_o, error_o;

   logic [N-1:0] man_yumi  = '0;
   logic         auto_yumi = 1'b1;
   logic         force_v   = 1'b0;
   int           unit_cap  = 4;
   int           cyc       = 0;
   int           checks    = 0;
   int           failures  = 0;

   always #5 clk_i = ~clk_i;

   bsg_fpu_add_sub_arbiter #(.e_p(8), .m_p(23), .num_req_p(N), .els_p(4)) dut
     (.clk_i(clk_i), .reset_i(reset_i)
     ,.v_i(v_i), .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .ready_o(ready_o)
     ,.v_o(v_o), .z_o(z_o), .flags_o(flags_o), .yumi_i(yumi_i)
     ,.fpu_v_o(fpu_v_o), .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_sub_o(fpu_sub_o)
     ,.fpu_en_o(fpu_en_o), .fpu_ready_i(fpu_ready_i), .fpu_v_i(fpu_v_i)
     ,.fpu_z_i(fpu_z_i), .fpu_flags_i(fpu_flags_i), .fpu_yumi_o(fpu_yumi_o)
     ,.error_o(error_o));

   // Stand-in unit: exact result for the 1.0+2.0 pair, integer arithmetic otherwise.
   function automatic logic [31:0] fake_z(logic [31:0] a, logic [31:0] b, logic s);
      if (!s && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return s ? a - b : a + b;
   endfunction

   function automatic logic [3:0] fake_f(logic [31:0] a, logic [31:0] b, logic s);
      return {s, a[31], b[31], 1'b0};
   endfunction

   logic [W-1:0] u_z [16];
   logic [3:0]   u_f [16];
   int           u_t [16];
   int           u_wr = 0;
   int           u_rd = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         u_wr <= 0;
         u_rd <= 0;
      end else begin
         if (fpu_v_o && fpu_ready_i) begin
            u_z[u_wr[3:0]] <= fake_z(fpu_a_o, fpu_b_o, fpu_sub_o);
            u_f[u_wr[3:0]] <= fake_f(fpu_a_o, fpu_b_o, fpu_sub_o);
            u_t[u_wr[3:0]] <= cyc;
            u_wr <= u_wr + 1;
         end
         if (fpu_yumi_o) u_rd <= u_rd + 1;
      end
   end

   assign fpu_ready_i = (u_wr - u_rd) < unit_cap;
   assign fpu_v_i     = force_v || ((u_wr != u_rd) && (cyc >= u_t[u_rd[3:0]] + 3));
   assign fpu_z_i     = u_z[u_rd[3:0]];
   assign fpu_flags_i = u_f[u_rd[3:0]];
   assign yumi_i      = auto_yumi ? v_o : man_yumi;

   int           exp_tag [$];
   logic [31:0]  exp_z   [$];
   logic [3:0]   exp_f   [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int g);
      exp_tag.push_back(g);
      exp_z.push_back(fake_z(a_i[g*W +: W], b_i[g*W +: W], sub_i[g]));
      exp_f.push_back(fake_f(a_i[g*W +: W], b_i[g*W +: W], sub_i[g]));
   endtask

   int          mon_t;
   logic [3:0]  mon_oh;
   logic [31:0] mon_z;
   logic [3:0]  mon_f;
   always @(negedge clk_i) begin
      if (!reset_i && (v_o & yumi_i) != '0) begin
         if (exp_tag.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected: got v_o=%b expected none outstanding", v_o);
         end else begin
            mon_t  = exp_tag.pop_front();
            mon_z  = exp_z.pop_front();
            mon_f  = exp_f.pop_front();
            mon_oh = 4'b0001 << mon_t;
            check("result", {v_o, z_o, flags_o}, {mon_oh, mon_z, mon_f});
         end
      end
   end

   function automatic int oh2idx(logic [3:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return i;
      return 0;
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_ops(input int k);
      for (int r = 0; r < N; r++) begin
         a_i[r*W +: W] = 32'h0100_0000 + 32'(k*16 + r);
         b_i[r*W +: W] = 32'h0000_0100 * 32'(r + 1);
         sub_i[r]      = 1'((k + r) % 2);
      end
   endtask

   task automatic clear_exp;
      exp_tag.delete();
      exp_z.delete();
      exp_f.delete();
   endtask

   task automatic do_reset;
      reset_i   = 1'b1;
      v_i       = '0;
      auto_yumi = 1'b1;
      man_yumi  = '0;
      force_v   = 1'b0;
      unit_cap  = 4;
      #1;
      clear_exp();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic issue_one(input string name, input logic [3:0] v, input logic [3:0] exp_ready);
      v_i = v;
      @(negedge clk_i);
      check(name, ready_o, exp_ready);
      if (exp_ready != 4'b0000) push_exp(oh2idx(exp_ready));
      tick();
   endtask

   task automatic drain(input string name);
      for (int c = 0; c < 40 && exp_tag.size() != 0; c++) tick();
      check(name, exp_tag.size(), 0);
   endtask

   typedef struct packed {
      logic [3:0] v;
      logic [3:0] exp_ready;
   } vec_t;
   vec_t tbl [15];

   logic [3:0] cap_exp [8];

   initial begin
      // Grant sequence from rr_ptr = 0, results consumed every cycle.
      tbl[0]  = {4'b1111, 4'b0001};
      tbl[1]  = {4'b1111, 4'b0010};
      tbl[2]  = {4'b1111, 4'b0100};
      tbl[3]  = {4'b1111, 4'b1000};
      tbl[4]  = {4'b1111, 4'b0001};
      tbl[5]  = {4'b1111, 4'b0010};
      tbl[6]  = {4'b1111, 4'b0100};
      tbl[7]  = {4'b1111, 4'b1000};
      tbl[8]  = {4'b0000, 4'b0000};
      tbl[9]  = {4'b1010, 4'b0010};
      tbl[10] = {4'b1001, 4'b1000};
      tbl[11] = {4'b0110, 4'b0010};
      tbl[12] = {4'b0011, 4'b0001};
      tbl[13] = {4'b1000, 4'b1000};
      tbl[14] = {4'b0000, 4'b0000};
      cap_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

      // Reset state, with requests pending
      v_i = 4'b1111;
      set_ops(0);
      @(negedge clk_i);
      check("rst_ready", ready_o, 4'b0000);
      check("rst_v_o", v_o, 4'b0000);
      check("rst_fpu_v", fpu_v_o, 1'b0);
      check("rst_fpu_yumi", fpu_yumi_o, 1'b0);
      check("rst_error", error_o, 1'b0);
      check("rst_count", dut.count_r, 0);
      check("fpu_en", fpu_en_o, 1'b1);
      v_i = '0;
      tick();
      reset_i = 1'b0;

      // Single request from requester 2
      a_i[2*W +: W] = 32'h3F80_0000;
      b_i[2*W +: W] = 32'h4000_0000;
      sub_i = '0;
      issue_one("single_grant", 4'b0100, 4'b0100);
      v_i = '0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk_i);
         check("single_latency", v_o, 4'b0000);
         tick();
      end
      @(negedge clk_i);
      check("single_v_o", v_o, 4'b0100);
      check("single_z", z_o, 32'h4040_0000);
      check("single_flags", flags_o, 4'b0000);
      tick();
      drain("drain_single");

      // Round-robin table
      do_reset();
      for (int i = 0; i < 15; i++) begin
         v_i = tbl[i].v;
         set_ops(i + 1);
         @(negedge clk_i);
         check("grant", ready_o, tbl[i].exp_ready);
         check("fpu_v", fpu_v_o, |tbl[i].v);
         if (tbl[i].exp_ready != 4'b0000) begin
            check("mux_a", fpu_a_o, a_i[oh2idx(tbl[i].exp_ready)*W +: W]);
            check("mux_sub", fpu_sub_o, sub_i[oh2idx(tbl[i].exp_ready)]);
            push_exp(oh2idx(tbl[i].exp_ready));
         end
         tick();
      end
      v_i = '0;
      drain("drain_table");
      check("error_quiet", error_o, 1'b0);

      // Capacity: unit never refuses, results held, tag FIFO must cap at 4
      unit_cap  = 8;
      auto_yumi = 1'b0;
      man_yumi  = '0;
      v_i       = 4'b1111;
      set_ops(20);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         check("cap_grant", ready_o, cap_exp[c]);
         check("cap_count", dut.count_r, (c < 4) ? c : 4);
         if (cap_exp[c] != 4'b0000) push_exp(oh2idx(cap_exp[c]));
         if (c == 7) begin
            check("cap_head", v_o, 4'b0001);
            check("cap_no_yumi", fpu_yumi_o, 1'b0);
         end
         tick();
      end
      v_i = '0;
      auto_yumi = 1'b1;
      drain("drain_cap");
      check("cap_count_end", dut.count_r, 0);

      // Same-cycle enqueue/dequeue at count 3, write pointer wraps 3->0
      do_reset();
      auto_yumi = 1'b0;
      unit_cap  = 8;
      set_ops(30);
      issue_one("ed_grant0", 4'b0001, 4'b0001);
      issue_one("ed_grant1", 4'b0010, 4'b0010);
      issue_one("ed_grant2", 4'b0100, 4'b0100);
      v_i = 4'b1000;
      man_yumi = 4'b0001;
      @(negedge clk_i);
      check("ed_count_pre", dut.count_r, 3);
      check("ed_wr_pre", dut.wr_ptr_r, 3);
      check("ed_grant3", ready_o, 4'b1000);
      check("ed_head", v_o, 4'b0001);
      check("ed_fpu_yumi", fpu_yumi_o, 1'b1);
      push_exp(3);
      tick();
      v_i = '0;
      man_yumi = '0;
      @(negedge clk_i);
      check("ed_count_post", dut.count_r, 3);
      check("ed_wr_post", dut.wr_ptr_r, 0);
      check("ed_rd_post", dut.rd_ptr_r, 1);
      tick();
      auto_yumi = 1'b1;
      drain("drain_ed");
      check("ed_rd_wrap", dut.rd_ptr_r, 0);
      check("ed_count_end", dut.count_r, 0);

      // Asynchronous reset with two ops in flight
      auto_yumi = 1'b0;
      issue_one("ar_grant1", 4'b0010, 4'b0010);
      issue_one("ar_grant2", 4'b0100, 4'b0100);
      v_i = '0;
      tick();
      v_i = 4'b1111;
      @(negedge clk_i);
      check("ar_head", v_o, 4'b0010);
      check("ar_grant3", ready_o, 4'b1000);
      #2;
      reset_i = 1'b1;
      #1;
      check("ar_v_o", v_o, 4'b0000);
      check("ar_ready", ready_o, 4'b0000);
      check("ar_fpu_v", fpu_v_o, 1'b0);
      check("ar_count", dut.count_r, 0);
      clear_exp();
      tick();
      reset_i = 1'b0;
      auto_yumi = 1'b1;
      issue_one("ar_first_grant", 4'b1111, 4'b0001);
      v_i = '0;
      drain("drain_ar");

      // Protocol errors: result with empty FIFO, then stray yumi
      force_v = 1'b1;
      @(negedge clk_i);
      check("err_v_same_cycle", error_o, 1'b0);
      check("err_v_no_v_o", v_o, 4'b0000);
      tick();
      force_v = 1'b0;
      @(negedge clk_i);
      check("err_v_set", error_o, 1'b1);
      tick();
      tick();
      @(negedge clk_i);
      check("err_v_sticky", error_o, 1'b1);
      do_reset();
      @(negedge clk_i);
      check("err_cleared", error_o, 1'b0);
      tick();
      auto_yumi = 1'b0;
      man_yumi  = 4'b0010;
      @(negedge clk_i);
      check("err_yumi_same_cycle", error_o, 1'b0);
      tick();
      man_yumi = '0;
      @(negedge clk_i);
      check("err_yumi_set", error_o, 1'b1);
      tick();
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish within 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
